raster_scan_counter: RTL and testbench
======================================

RASTER_SCAN_COUNTER -- requirements
Module: raster_scan_counter

Interface
REQ-001 Parameter X_W, default 8: width of row index X_o and x_end_i.
REQ-002 Parameter Y_W, default 8: width of column index Y_o and y_end_i.
REQ-003 Parameter STEP, default 1: column stride, legal range 1..2**Y_W-1.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports as below.
REQ-005 clk_i  input  1  clock; all state updates on its rising edge.
REQ-006 rst_i  input  1  synchronous reset, active high.
REQ-007 start_i  input  1  begin a scan; honoured only in IDLE.
REQ-008 abort_i  input  1  cancel the scan from any state.
REQ-009 x_end_i  input  X_W  last row index, inclusive; sampled on an accepted start.
REQ-010 y_end_i  input  Y_W  last column limit, inclusive; sampled on an accepted start.
REQ-011 ready_i  input  1  consumer accepts the current coordinate.
REQ-012 X_o  output  X_W  current row index, outer loop; registered.
REQ-013 Y_o  output  Y_W  current column index, inner loop; registered.
REQ-014 valid_o  output  1  X_o and Y_o carry a coordinate.
REQ-015 row_last_o  output  1  current coordinate is the last one in its row.
REQ-016 finished_o  output  1  current coordinate is the last one of the scan.
REQ-017 busy_o  output  1  state is RUN or DONE.
REQ-018 done_o  output  1  one-cycle pulse after the final transfer.

Function
REQ-019 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-020 IDLE with start_i=1: the block SHALL latch x_end_i and y_end_i into internal registers xe and ye, load X_o=0 and Y_o=0, and enter RUN. valid_o SHALL be 1 on the next cycle (latency 1).
REQ-021 start_i in RUN or DONE SHALL be ignored; xe and ye SHALL NOT change until the next accepted start.
REQ-022 In RUN, valid_o=1. A transfer occurs on each cycle with valid_o=1 and ready_i=1. While ready_i=0, X_o and Y_o SHALL hold.
REQ-023 Row end is defined as Y_o+STEP > ye, evaluated at Y_W+1 bits with no overflow. row_last_o = valid_o AND row end.
REQ-024 finished_o SHALL equal row_last_o AND (X_o == xe).
REQ-025 On a transfer that is not row end: Y_o SHALL increase by STEP.
REQ-026 On a transfer at row end that is not finished: Y_o SHALL go to 0 and X_o SHALL increase by 1.
REQ-027 On a transfer with finished_o=1: the block SHALL enter DONE, with valid_o=0.
REQ-028 DONE SHALL last exactly one cycle with done_o=1, then enter IDLE with X_o=0 and Y_o=0.
REQ-029 A scan SHALL produce exactly (xe+1)*(floor(ye/STEP)+1) transfers, in raster order. There is no wrap-around beyond xe.
REQ-030 xe=0 and ye=0 SHALL give a single transfer with row_last_o=1 and finished_o=1.
REQ-031 STEP > ye SHALL give one coordinate per row, with Y_o=0.
REQ-032 abort_i=1 in any state: on the next edge the block SHALL enter IDLE with X_o=0, Y_o=0, valid_o=0, and no done_o pulse.
REQ-033 abort_i SHALL take priority over start_i and over any transfer in the same cycle.
REQ-034 In IDLE, valid_o, row_last_o, finished_o, busy_o and done_o SHALL all be 0.

Reset
REQ-035 rst_i=1 at a rising edge SHALL force IDLE and set X_o=0, Y_o=0, xe=0, ye=0 and all 1-bit outputs to 0. rst_i SHALL take priority over abort_i and start_i.
REQ-036 rst_i asserted during RUN or DONE SHALL leave no pending done_o pulse; the first cycle after reset SHALL be IDLE.

Verification
REQ-037 Directed tests SHALL cover the following scenarios.
- STEP=1, x_end=2, y_end=3, ready_i held 1 -> 12 transfers (0,0)..(2,3); row_last_o at Y=3; finished_o at (2,3); done_o high one cycle later; then IDLE.
- Same config with ready_i randomised -> identical coordinate sequence; X_o and Y_o stable on every cycle with valid_o=1 and ready_i=0.
- STEP=2, y_end=4 -> Y sequence 0,2,4 per row. STEP=2, y_end=5 -> Y sequence 0,2,4 with row_last_o at 4.
- x_end=0, y_end=0 -> single transfer with finished_o=1; done_o pulses; 3 cycles from start to IDLE.
- abort_i on the 5th transfer -> IDLE next cycle, no done_o. rst_i mid-RUN -> same result. start_i with new ends during RUN -> ignored; original sequence completes.

Source files
------------

// File: rtl/raster_scan_counter.sv
// Raster-order coordinate generator: X is the outer (row) loop, Y the inner (column) loop
// advancing by STEP, handshaked with valid/ready and bounded by ends latched at start.
module raster_scan_counter #(
  parameter int unsigned X_W  = 8,
  parameter int unsigned Y_W  = 8,
  parameter int unsigned STEP = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           abort_i,
  input  logic [X_W-1:0] x_end_i,
  input  logic [Y_W-1:0] y_end_i,
  input  logic           ready_i,
  output logic [X_W-1:0] X_o,
  output logic [Y_W-1:0] Y_o,
  output logic           valid_o,
  output logic           row_last_o,
  output logic           finished_o,
  output logic           busy_o,
  output logic           done_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [Y_W:0] StepExt = (Y_W+1)'(STEP);

  state_e         state_q;
  logic [X_W-1:0] xe_q;
  logic [Y_W-1:0] ye_q;
  logic [Y_W:0]   y_next;
  logic           row_end;

  // One extra bit so Y_o + STEP never wraps before the comparison.
  assign y_next  = {1'b0, Y_o} + StepExt;
  assign row_end = y_next > {1'b0, ye_q};

  always_comb begin
    valid_o    = (state_q == StRun);
    row_last_o = valid_o & row_end;
    finished_o = row_last_o & (X_o == xe_q);
    busy_o     = (state_q != StIdle);
    done_o     = (state_q == StDone);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      X_o     <= '0;
      Y_o     <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
    end else if (abort_i) begin
      state_q <= StIdle;
      X_o     <= '0;
      Y_o     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            xe_q    <= x_end_i;
            ye_q    <= y_end_i;
            X_o     <= '0;
            Y_o     <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (ready_i) begin
            if (finished_o) begin
              state_q <= StDone;
            end else if (row_end) begin
              Y_o <= '0;
              X_o <= X_o + X_W'(1);
            end else begin
              Y_o <= y_next[Y_W-1:0];
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          X_o     <= '0;
          Y_o     <= '0;
        end
        default: begin
          state_q <= StIdle;
          X_o     <= '0;
          Y_o     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_raster_scan_counter.sv
// Scoreboard bench: two instances (STEP=1 and STEP=2) share stimulus; each has its own
// expected-coordinate queue, popped by a negedge monitor on every accepted transfer.
module tb_raster_scan_counter;

  logic clk = 1'b0;
  logic rst_i = 1'b1, start_i = 1'b0, abort_i = 1'b0, ready_i = 1'b0;
  logic [7:0] x_end_i = '0, y_end_i = '0;

  logic [7:0] x0, y0, x1, y1;
  logic v0, rl0, f0, b0, d0, v1, rl1, f1, b1, d1;

  int vectors = 0;
  int errors  = 0;

  logic [17:0] q0[$];
  logic [17:0] q1[$];

  int         n[2]     = '{0, 0};
  logic       pv[2]    = '{1'b0, 1'b0};
  logic       prdy[2]  = '{1'b0, 1'b0};
  logic       pab[2]   = '{1'b0, 1'b0};
  logic       pfin[2]  = '{1'b0, 1'b0};
  logic       pdone[2] = '{1'b0, 1'b0};
  logic [7:0] px[2]    = '{8'd0, 8'd0};
  logic [7:0] py[2]    = '{8'd0, 8'd0};

  always #5 clk = ~clk;

  raster_scan_counter #(.X_W(8), .Y_W(8), .STEP(1)) u_s1 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .x_end_i(x_end_i), .y_end_i(y_end_i), .ready_i(ready_i),
    .X_o(x0), .Y_o(y0), .valid_o(v0), .row_last_o(rl0), .finished_o(f0),
    .busy_o(b0), .done_o(d0)
  );

  raster_scan_counter #(.X_W(8), .Y_W(8), .STEP(2)) u_s2 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .x_end_i(x_end_i), .y_end_i(y_end_i), .ready_i(ready_i),
    .X_o(x1), .Y_o(y1), .valid_o(v1), .row_last_o(rl1), .finished_o(f1),
    .busy_o(b1), .done_o(d1)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic mon(input int i, input logic [7:0] x, input logic [7:0] y, input logic v,
                     input logic rl, input logic fin, input logic b, input logic d);
    logic [17:0] e;
    if (v && ready_i && !abort_i && !rst_i) begin
      n[i]++;
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
        chk($sformatf("unexpected_xfer%0d", i), {14'd0, x, y, rl, fin}, 32'h0);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("coord%0d", i), {14'd0, x, y, rl, fin}, {14'd0, e});
      end
    end
    if (pab[i]) chk($sformatf("idle_after_abort_rst%0d", i), {v, b, d, x, y}, '0);
    if (pdone[i]) chk($sformatf("idle_after_done%0d", i), {b, x, y}, '0);
    chk($sformatf("done_pulse%0d", i), d, pfin[i]);
    chk($sformatf("busy%0d", i), b, v | d);
    if (!v) chk($sformatf("flags_no_valid%0d", i), {rl, fin}, 2'b00);
    if (pv[i] && !prdy[i] && !pab[i] && v)
      chk($sformatf("hold%0d", i), {x, y}, {px[i], py[i]});
    pv[i]    = v;
    prdy[i]  = ready_i;
    pab[i]   = abort_i | rst_i;
    pfin[i]  = v & ready_i & fin & !abort_i & !rst_i;
    pdone[i] = d & !abort_i & !rst_i;
    px[i]    = x;
    py[i]    = y;
  endtask

  always @(negedge clk) begin
    mon(0, x0, y0, v0, rl0, f0, b0, d0);
    mon(1, x1, y1, v1, rl1, f1, b1, d1);
  end

  // Expected raster order for one instance, truncated after `limit` transfers.
  task automatic push_one(input int inst, input int s, input int xe, input int ye,
                          input int limit);
    int cnt = 0;
    logic rl;
    for (int x = 0; x <= xe; x++) begin
      for (int y = 0; y <= ye; y += s) begin
        rl = (y + s > ye);
        if (cnt < limit) begin
          if (inst == 0) q0.push_back({x[7:0], y[7:0], rl, rl && (x == xe)});
          else           q1.push_back({x[7:0], y[7:0], rl, rl && (x == xe)});
        end
        cnt++;
      end
    end
  endtask

  task automatic push_scan(input int xe, input int ye, input int limit);
    push_one(0, 1, xe, ye, limit);
    push_one(1, 2, xe, ye, limit);
  endtask

  task automatic do_start(input int xe, input int ye);
    n[0] = 0;
    n[1] = 0;
    x_end_i = xe[7:0];
    y_end_i = ye[7:0];
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input bit rand_ready);
    int k;
    for (k = 0; k < 400; k++) begin
      if (!b0 && !b1) break;
      ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
    end
    if (k == 400) chk("timeout", 32'd1, 32'd0);
    ready_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic end_scan(input string name, input int exp0, input int exp1);
    chk({name, "_count_s1"}, n[0], exp0);
    chk({name, "_count_s2"}, n[1], exp1);
    chk({name, "_queue_left"}, q0.size() + q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state_s1", {v0, rl0, f0, b0, d0, x0, y0}, '0);
    chk("reset_state_s2", {v1, rl1, f1, b1, d1, x1, y1}, '0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    // 3x4 grid, ready held: 12 transfers with STEP=1, Y=0,2 -> 6 with STEP=2.
    push_scan(2, 3, 1000);
    do_start(2, 3);
    chk("first_valid_latency", {v0, x0, y0}, {1'b1, 16'h0000});
    wait_idle(1'b0);
    end_scan("grid_ready", 12, 6);

    // Same grid, random backpressure.
    push_scan(2, 3, 1000);
    do_start(2, 3);
    wait_idle(1'b1);
    end_scan("grid_random", 12, 6);

    // y_end=4: STEP=2 gives 0,2,4; y_end=5: still 0,2,4 with row_last at 4.
    push_scan(1, 4, 1000);
    do_start(1, 4);
    wait_idle(1'b1);
    end_scan("yend4", 10, 6);
    push_scan(1, 5, 1000);
    do_start(1, 5);
    wait_idle(1'b0);
    end_scan("yend5", 12, 6);

    // STEP > ye: one coordinate per row.
    push_scan(3, 1, 1000);
    do_start(3, 1);
    wait_idle(1'b0);
    end_scan("step_gt_ye", 8, 4);

    // Single-point scan: start -> RUN -> DONE -> IDLE.
    push_scan(0, 0, 1000);
    ready_i = 1'b1;
    do_start(0, 0);
    chk("single_run", {v0, rl0, f0, b0, d0}, 5'b11110);
    @(posedge clk); #1;
    chk("single_done", {v0, b0, d0}, 3'b011);
    @(posedge clk); #1;
    chk("single_idle", {v0, b0, d0, x0, y0}, '0);
    ready_i = 1'b0;
    end_scan("single", 1, 1);

    // Abort while the 5th coordinate is offered.
    push_scan(2, 3, 4);
    ready_i = 1'b1;
    do_start(2, 3);
    repeat (4) begin @(posedge clk); #1; end
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    ready_i = 1'b0;
    chk("abort_idle", {b0, b1, d0, d1}, 4'b0000);
    repeat (2) begin @(posedge clk); #1; end
    end_scan("abort", 4, 4);

    // Reset mid-scan.
    push_scan(2, 3, 4);
    ready_i = 1'b1;
    do_start(2, 3);
    repeat (4) begin @(posedge clk); #1; end
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    ready_i = 1'b0;
    chk("rst_idle", {b0, b1, d0, d1, x0, y0}, '0);
    repeat (2) begin @(posedge clk); #1; end
    end_scan("rst_mid", 4, 4);

    // A new start with different ends during RUN must not disturb the scan.
    push_scan(2, 3, 1000);
    do_start(2, 3);
    ready_i = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    x_end_i = 8'd1;
    y_end_i = 8'd1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_idle(1'b0);
    end_scan("start_ignored", 12, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
